// File: rtl/sram_pkg.sv
// Shared types for the banked SRAM model: FSM state encoding and byte width.
package sram_pkg;
  typedef enum logic {CLEAR, IDLE} sram_state_e;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/sram_banked_bw_if.sv
// Access bus of the banked SRAM: CEB/WEB strobes, byte mask, address, data and status.
interface sram_banked_bw_if #(
  parameter int numWord     = 2048,
  parameter int numBit      = 32,
  parameter int numWordAddr = $clog2(numWord)
) ();
  logic                   CEB;
  logic                   WEB;
  logic [numBit/8-1:0]    BWEB;
  logic [numWordAddr-1:0] A;
  logic [numBit-1:0]      D;
  logic [numBit-1:0]      Q;
  logic                   QVALID;
  logic                   READY;

  modport master (output CEB, WEB, BWEB, A, D, input Q, QVALID, READY);
  modport slave  (input CEB, WEB, BWEB, A, D, output Q, QVALID, READY);
endinterface

// File: rtl/sram_bank.sv
// One bank of the interleaved SRAM: byte-masked write, full-row clear, registered read.
module sram_bank
  import sram_pkg::*;
#(
  parameter int ROWS   = 512,
  parameter int numBit = 32,
  parameter int ROW_W  = 9
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [numBit/BYTE_W-1:0] bweb,
  input  logic [ROW_W-1:0]         row,
  input  logic [numBit-1:0]        d,
  output logic [numBit-1:0]        q
);
  logic [numBit-1:0] mem [ROWS];

  // Array itself is never reset; the post-reset sweep zeroes it through clr.
  always_ff @(posedge gclk) begin
    if (clr) begin
      mem[row] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < numBit/BYTE_W; k++)
        if (!bweb[k]) mem[row][k*BYTE_W +: BYTE_W] <= d[k*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)    q <= '0;
    else if (rd_en) q <= mem[row];
  end
endmodule

// File: rtl/sram_banked_bw.sv
// Bank-interleaved single-port SRAM with byte writes and post-reset clear sweep.
// Define SRAM_OUT_REG_EN for an extra output register stage (read latency 2).
module sram_banked_bw
  import sram_pkg::*;
#(
  parameter int numWord     = 2048,
  parameter int numBit      = 32,
  parameter int numBank     = 4,
  parameter int numWordAddr = $clog2(numWord)
) (
  input  logic         CLK,
  input  logic         RSTB,
  sram_banked_bw_if.slave bus
);
  localparam int ROWS     = numWord / numBank;
  localparam int LOG_BANK = $clog2(numBank);
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BANK_W   = (numBank > 1) ? LOG_BANK : 1;
`ifdef SRAM_OUT_REG_EN
  localparam int STAGES   = 2;
`else
  localparam int STAGES   = 1;
`endif

  sram_state_e state, state_nx;
  logic [ROW_W-1:0] cnt, cnt_nx;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        cnt_nx = cnt + ROW_W'(1);
        if (cnt == ROW_W'(ROWS-1)) state_nx = IDLE;
      end
      default: ;
    endcase
  end

  logic clearing, acc, wr, rd;
  logic [BANK_W-1:0] sel, bsel_q;
  logic [ROW_W-1:0]  a_row, row_mux;

  assign clearing = (state == CLEAR);
  assign acc      = !clearing && !bus.CEB;
  assign wr       = acc && !bus.WEB;
  assign rd       = acc && bus.WEB;
  assign sel      = (numBank > 1) ? BANK_W'(bus.A) : '0;
  assign a_row    = ROW_W'(bus.A >> LOG_BANK);
  // Clear sweep and normal access share each bank's single row port.
  assign row_mux  = clearing ? cnt : a_row;

  logic [numBank-1:0][numBit-1:0] bank_q;

  for (genvar g = 0; g < numBank; g++) begin : g_bank
    sram_bank #(.ROWS(ROWS), .numBit(numBit), .ROW_W(ROW_W)) u_bank (
      .gclk   (CLK),
      .grst_n (RSTB),
      .clr    (clearing),
      .wr_en  (wr && (sel == BANK_W'(g))),
      .rd_en  (rd && (sel == BANK_W'(g))),
      .bweb   (bus.BWEB),
      .row    (row_mux),
      .d      (bus.D),
      .q      (bank_q[g])
    );
  end

  // Bank index follows the last read so Q holds across idle and write cycles.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)   bsel_q <= '0;
    else if (rd) bsel_q <= sel;
  end

  logic [STAGES:1] vld_pipe;
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) vld_pipe <= '0;
    else       vld_pipe <= (vld_pipe << 1) | STAGES'(rd);
  end

  logic [numBit-1:0] q_mux;
  assign q_mux = bank_q[bsel_q];

`ifdef SRAM_OUT_REG_EN
  logic [numBit-1:0] q_reg;
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)            q_reg <= '0;
    else if (vld_pipe[1]) q_reg <= q_mux;
  end
  assign bus.Q = q_reg;
`else
  assign bus.Q = q_mux;
`endif

  assign bus.QVALID = vld_pipe[STAGES];
  assign bus.READY  = (state == IDLE);
endmodule
